// File: rtl/pp_mult_sched.sv
// Shift-add multiplier shared by two requesters through a round-robin arbiter.
// Each accepted pair takes W accumulate cycles, then waits for the consumer in DONE.
module pp_mult_sched #(
    parameter int W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_prod,
    output logic           rsp_id,
    output logic           busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           last_id;
    logic           id_q;

    logic           grant0;
    logic           grant1;
    logic           accept;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] acc_next;

    // Valid/ready: a pair transfers on the edge where valid and ready are both high.
    // Readies are only ever offered in IDLE and never look at rsp_ready.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || !last_id);
        grant0     = req0_valid && !grant1;
        req0_ready = rst_n && (state == IDLE) && grant0;
        req1_ready = rst_n && (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        pp         = b_q[cnt] ? ({{W{1'b0}}, a_q} << cnt) : '0;
        acc_next   = acc + pp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            last_id   <= 1'b1;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_prod  <= '0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= req1_ready ? req1_a : req0_a;
                        b_q     <= req1_ready ? req1_b : req0_b;
                        id_q    <= req1_ready;
                        last_id <= req1_ready;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    // Last row: publish the final sum directly so DONE shows it at once.
                    if (cnt == CW'(W - 1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_prod  <= acc_next;
                        rsp_id    <= id_q;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_mult_sched.sv
// Directed bench for pp_mult_sched: stimulus pushes expected {id, product},
// a negedge monitor pops and compares every completed response handshake.
module tb_pp_mult_sched;

  localparam int W  = 6;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp_valid, rsp_ready;
  logic [PW-1:0] rsp_prod;
  logic          rsp_id;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [PW:0] exp_q[$];
  int          rsp_t_q[$];

  pp_mult_sched #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_prod   (rsp_prod),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [PW:0] e;
    #2;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rsp_t_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d prod %0d, expected no response", rsp_id, rsp_prod);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", {31'd0, rsp_id}, {31'd0, e[PW]});
        check("rsp_prod", {20'd0, rsp_prod}, {20'd0, e[PW-1:0]});
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic id, input logic [PW-1:0] prod);
    exp_q.push_back({id, prod});
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        t = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_rsp: got no rsp_valid within 40 cycles, expected rsp_valid=1");
  endtask

  task automatic wait_ready(input logic id, output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        t = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_ready: got no req%0d_ready within 40 cycles, expected grant", id);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy === 1'b0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: got busy=1 for 40 cycles, expected busy=0");
  endtask

  initial begin
    int c0, t, gid;
    logic [PW-1:0] prod;

    rst_n      = 1'b0;
    req0_valid = 1'b1; req0_a = 6'd1; req0_b = 6'd1;
    req1_valid = 1'b1; req1_a = 6'd1; req1_b = 6'd1;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_req0_ready", {31'd0, req0_ready}, 0);
    check("reset_req1_ready", {31'd0, req1_ready}, 0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_rsp_prod", {20'd0, rsp_prod}, 0);
    check("reset_rsp_id", {31'd0, rsp_id}, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b1;

    // single request: 3*5
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd3; req0_b = 6'd5;
    #1;
    check("t1_req0_ready", {31'd0, req0_ready}, 1);
    c0 = cyc;
    push_exp(1'b0, 12'd15);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      check("t1_busy", {31'd0, busy}, 1);
      check("t1_rsp_valid", {31'd0, rsp_valid}, (k == 7) ? 1 : 0);
      if (k == 7) check("t1_latency", cyc - c0, 7);
      if (k < 7) @(negedge clk);
    end
    @(negedge clk);
    #1;
    check("t1_busy_after", {31'd0, busy}, 0);

    // simultaneous first request after reset
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd7;  req0_b = 6'd9;
    req1_valid = 1'b1; req1_a = 6'd10; req1_b = 6'd11;
    #1;
    check("t2_req0_ready", {31'd0, req0_ready}, 1);
    check("t2_req1_ready", {31'd0, req1_ready}, 0);
    c0 = cyc;
    push_exp(1'b0, 12'd63);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("t2_req1_blocked", {31'd0, req1_ready}, 0);
    wait_ready(1'b1, t);
    check("t2_req1_accept_cycle", t - c0, 8);
    push_exp(1'b1, 12'd110);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(t);
    check("t2_second_rsp_cycle", t - c0, 15);

    // fairness: both held valid for six operations
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    rsp_t_q.delete();
    req0_valid = 1'b1; req0_a = 6'd5; req0_b = 6'd12;
    req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd13;
    for (int g = 0; g < 6; g++) begin
      gid = -1;
      for (int i = 0; i < 40; i++) begin
        #1;
        if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
          gid = (req1_ready === 1'b1) ? 1 : 0;
          break;
        end
        @(negedge clk);
      end
      check("t3_grant_id", gid, g % 2);
      if (gid >= 0) begin
        prod = (gid == 1) ? 12'd117 : 12'd60;
        push_exp(gid[0], prod);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 60 && rsp_t_q.size() < 6; i++) @(negedge clk);
    check("t3_rsp_count", rsp_t_q.size(), 6);
    if (rsp_t_q.size() >= 6)
      for (int i = 1; i < 6; i++) check("t3_rsp_spacing", rsp_t_q[i] - rsp_t_q[i-1], 8);

    // backpressure with extreme operands
    wait_idle();
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 6'd63; req0_b = 6'd63;
    #1;
    check("t4_req0_ready", {31'd0, req0_ready}, 1);
    push_exp(1'b0, 12'd3969);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 6'd2; req1_b = 6'd3;
    wait_rsp(t);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("t4_hold_valid", {31'd0, rsp_valid}, 1);
      check("t4_hold_prod", {20'd0, rsp_prod}, 3969);
      check("t4_hold_id", {31'd0, rsp_id}, 0);
      check("t4_no_accept", {31'd0, req1_ready}, 0);
      if (k == 5) rsp_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    check("t4_accept_after", {31'd0, req1_ready}, 1);
    push_exp(1'b1, 12'd6);
    @(negedge clk);
    req1_valid = 1'b0;

    // zero operand keeps full latency
    wait_idle();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 6'd0; req1_b = 6'd63;
    #1;
    check("t5_req1_ready", {31'd0, req1_ready}, 1);
    c0 = cyc;
    push_exp(1'b1, 12'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(t);
    check("t5_latency", t - c0, 7);

    // reset in the middle of CALC
    @(negedge clk);
    wait_idle();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd4; req0_b = 6'd4;
    #1;
    check("t6_req0_ready", {31'd0, req0_ready}, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 6'd2; req0_b = 6'd9;
    req1_valid = 1'b1; req1_a = 6'd3; req1_b = 6'd7;
    @(negedge clk);
    #1;
    check("t6_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_req0_ready", {31'd0, req0_ready}, 0);
    check("t6_rst_req1_ready", {31'd0, req1_ready}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_tie_req0_ready", {31'd0, req0_ready}, 1);
    check("t6_tie_req1_ready", {31'd0, req1_ready}, 0);
    push_exp(1'b0, 12'd18);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_ready(1'b1, t);
    push_exp(1'b1, 12'd21);
    @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (12) @(negedge clk);
    check("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pp_mult_sched.md
# pp_mult_sched

Sequential shift-add multiply scheduler that time-shares one partial-product accumulator between two requesters. Each accepted operand pair is multiplied over W cycles, one partial-product row per cycle, instead of a full combinational array. A round-robin arbiter gives fair access to the shared datapath, and a valid/ready response port returns the product. It sits between two operand producers and one result consumer.

## Interface
- W, default 6: operand width in bits; product width is 2W.
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- req0_valid, input, 1: requester 0 holds an operand pair.
- req0_ready, output, 1: requester 0's pair is accepted this cycle.
- req0_a, input, W: requester 0 multiplicand.
- req0_b, input, W: requester 0 multiplier.
- req1_valid, input, 1: requester 1 holds an operand pair.
- req1_ready, output, 1: requester 1's pair is accepted this cycle.
- req1_a, input, W: requester 1 multiplicand.
- req1_b, input, W: requester 1 multiplier.
- rsp_valid, output, 1: product available.
- rsp_ready, input, 1: consumer takes the product.
- rsp_prod, output, 2W: unsigned product a*b.
- rsp_id, output, 1: requester index that owns rsp_prod.
- busy, output, 1: high in CALC or DONE.

## Operation
- **State machine.** States are IDLE, CALC and DONE.
- **IDLE.**
  - If any reqN_valid is high, grant exactly one requester; its reqN_ready is high combinationally in this cycle.
  - On the edge, latch a, b and the id; clear acc and cnt; go to CALC.
  - With no valid request, stay in IDLE. Both readies are low.
- **Arbitration.** Round-robin with a 1-bit pointer last_id.
  - When both requests are valid, grant the id that is not last_id.
  - When only one is valid, grant it regardless of the pointer.
  - last_id updates to the granted id on acceptance.
- **CALC.** Runs for cycles cnt = 0..W-1.
  - If b[cnt]=1, then acc <= acc + (a << cnt), computed at 2W bits.
  - cnt increments each cycle.
  - After the cnt=W-1 update, go to DONE.
- **DONE.**
  - rsp_valid=1; rsp_prod=acc; rsp_id=latched id.
  - Hold until rsp_ready=1, then go to IDLE on that edge.
  - Both readies are low in CALC and DONE.
- **Arithmetic.** Unsigned only. acc is 2W bits and cannot overflow, since (2^W-1)^2 < 2^2W.
- **Fixed latency.** Zero operands still take the full W CALC cycles. There is no early termination.
- **Output stability.** rsp_prod and rsp_id hold their value from entry to DONE until the next acceptance; they are not cleared on leaving DONE.
- **Input stability.** Requester inputs are ignored outside the IDLE grant cycle, so operand changes during CALC have no effect.
- **Reset.** While rst_n=0, on every edge:
  - state=IDLE, acc=0, cnt=0, last_id=1 (so req0 wins the first tie).
  - rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0.
  - req0_ready=0 and req1_ready=0; both are gated by rst_n.
- **Reset mid-operation.** Reset asserted in CALC or DONE discards the in-flight operation; no response is produced for it.

## Timing
- **Request to response.** Acceptance at cycle 0 (reqN_valid & reqN_ready at edge 0). CALC occupies cycles 1..W. rsp_valid rises in cycle W+1, which is cycle 7 for W=6.
- **Zero-wait response.** If rsp_ready=1 in cycle W+1, the state is IDLE in cycle W+2 and the next acceptance can happen in cycle W+2.
- **Throughput.** Minimum W+2 cycles per operation, i.e. 8 for W=6.
- **Backpressure.** Each cycle of rsp_ready=0 in DONE adds one cycle.
- **Combinational path.** readies depend combinationally on reqN_valid, state and last_id. They never depend on rsp_ready.
- **Grant window.** A request that drops valid before its grant is simply not served. There is no latching of valid.

## Test plan
- **Single request.** Reset, then req0 a=3, b=5 for one cycle with W=6 -> req0_ready=1 in cycle 0, rsp_valid=1 in cycle 7, rsp_prod=15, rsp_id=0, busy=1 in cycles 1–7.
- **Simultaneous first request after reset.** req0 (7,9) and req1 (10,11) both valid, rsp_ready=1 -> req0 accepted first, giving 63 with id 0. req1 is accepted in cycle 8, giving 110 with id 1 in cycle 15.
- **Fairness.** Both requesters held valid continuously for 6 operations -> grant ids alternate 0,1,0,1,0,1. Every response is exactly 8 cycles after the previous one.
- **Backpressure and extremes.** 63×63 with rsp_ready=0 for 5 cycles after rsp_valid -> rsp_prod=3969 and rsp_id held stable for 6 cycles. No acceptance occurs until the handshake.
- **Zero operand.** req1 a=0, b=63 -> rsp_prod=0, still in cycle 7.
- **Reset mid-CALC.** rst_n=0 in cycle 3 of an operation -> rsp_valid, busy and the readies are 0 next cycle. No response for the aborted operation appears. After release, req0 has tie priority.
